// File: rtl/top_writeback.sv
// WriteBack stage: selects register-file write data, issues a one-cycle write strobe, owns the PC.
// Optional macro WB_INSTRET_EN adds a 64-bit retired-instruction counter port (instret).
module top_writeback #(
`ifdef RV64I
    parameter int XLEN = 64,
`else
    parameter int XLEN = 32,
`endif
    parameter int OPLEN = 8,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int WB_WE_BIT = 0,
    parameter int WB_SRC_BIT_M = 2,
    parameter int WB_SRC_BIT_L = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             phase_writeback,
    input  logic [OPLEN-1:0] decoded_op_mw,
    input  logic             jump_state_mw,
    input  logic [4:0]       rdsel_mw,
    input  logic [XLEN-1:0]  next_pc_mw,
    input  logic [XLEN-1:0]  alu_out_mw,
    input  logic [XLEN-1:0]  mem_out_mw,
    output logic [XLEN-1:0]  current_pc,
    output logic             rd_we_wb,
    output logic [4:0]       rd_sel_wb,
    output logic [XLEN-1:0]  rd_data_wb,
`ifdef WB_INSTRET_EN
    output logic [63:0]      instret,
`endif
    output logic             stall_writeback
);

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_MEM  = 2'b01,
        SRC_LINK = 2'b10,
        SRC_RSVD = 2'b11
    } wb_src_e;

    wb_src_e         src;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] wb_data;
    logic            wr;

    // Only the write-enable and source bits matter here; the rest of the opcode is ignored.
    logic unused_op;
    assign unused_op = ^decoded_op_mw;

    assign src      = wb_src_e'(decoded_op_mw[WB_SRC_BIT_M:WB_SRC_BIT_L]);
    assign pc_plus4 = current_pc + XLEN'(4);
    assign wr       = decoded_op_mw[WB_WE_BIT] & (rdsel_mw != 5'd0) & (src != SRC_RSVD);

    // LINK uses the PC before this cycle's update.
    always_comb begin
        wb_data = '0;
        case (src)
            SRC_ALU:  wb_data = alu_out_mw;
            SRC_MEM:  wb_data = mem_out_mw;
            SRC_LINK: wb_data = pc_plus4;
            default:  wb_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            current_pc <= RESET_VECTOR;
            rd_we_wb   <= 1'b0;
            rd_sel_wb  <= '0;
            rd_data_wb <= '0;
        end else if (phase_writeback) begin
            current_pc <= jump_state_mw ? next_pc_mw : pc_plus4;
            rd_we_wb   <= wr;
            rd_sel_wb  <= rdsel_mw;
            rd_data_wb <= wb_data;
        end else begin
            rd_we_wb   <= 1'b0;
        end
    end

`ifdef WB_INSTRET_EN
    // Every phase cycle retires, including reserved-source and x0 writes.
    always_ff @(posedge clk) begin
        if (rst)
            instret <= '0;
        else if (phase_writeback)
            instret <= instret + 64'd1;
    end
`endif

    assign stall_writeback = 1'b0;

endmodule

// File: tb/tb_top_writeback.sv
// Directed self-checking bench for top_writeback; counter checks only when WB_INSTRET_EN is defined.
module tb_top_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        phase_writeback;
    logic [7:0]  decoded_op_mw;
    logic        jump_state_mw;
    logic [4:0]  rdsel_mw;
    logic [31:0] next_pc_mw;
    logic [31:0] alu_out_mw;
    logic [31:0] mem_out_mw;
    logic [31:0] current_pc;
    logic        rd_we_wb;
    logic [4:0]  rd_sel_wb;
    logic [31:0] rd_data_wb;
    logic        stall_writeback;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    top_writeback dut (
        .clk             (clk),
        .rst             (rst),
        .phase_writeback (phase_writeback),
        .decoded_op_mw   (decoded_op_mw),
        .jump_state_mw   (jump_state_mw),
        .rdsel_mw        (rdsel_mw),
        .next_pc_mw      (next_pc_mw),
        .alu_out_mw      (alu_out_mw),
        .mem_out_mw      (mem_out_mw),
        .current_pc      (current_pc),
        .rd_we_wb        (rd_we_wb),
        .rd_sel_wb       (rd_sel_wb),
        .rd_data_wb      (rd_data_wb),
`ifdef WB_INSTRET_EN
        .instret         (instret),
`endif
        .stall_writeback (stall_writeback)
    );

    // Drive one phase cycle starting at a negedge; returns at the next negedge.
    task automatic issue(input logic we, input logic [1:0] src, input logic [4:0] rd,
                         input logic jmp, input logic [31:0] npc,
                         input logic [31:0] alu, input logic [31:0] mem);
        decoded_op_mw   = {5'b0, src, we};
        rdsel_mw        = rd;
        jump_state_mw   = jmp;
        next_pc_mw      = npc;
        alu_out_mw      = alu;
        mem_out_mw      = mem;
        phase_writeback = 1'b1;
        @(negedge clk);
        phase_writeback = 1'b0;
    endtask

    task automatic set_pc(input logic [31:0] pc);
        issue(1'b0, 2'b11, 5'd0, 1'b1, pc, 32'h0, 32'h0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        phase_writeback = 1'b0;
        decoded_op_mw = '0; jump_state_mw = 0; rdsel_mw = 0;
        next_pc_mw = 0; alu_out_mw = 0; mem_out_mw = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (current_pc !== 32'h0) begin failures++; $display("FAIL reset_pc cyc=%0d got=%h exp=0", i, current_pc); end
            checks++;
            if (rd_we_wb !== 1'b0) begin failures++; $display("FAIL reset_we cyc=%0d got=%b exp=0", i, rd_we_wb); end
            checks++;
            if (rd_sel_wb !== 5'd0 || rd_data_wb !== 32'h0) begin failures++; $display("FAIL reset_rd cyc=%0d sel=%0d data=%h exp=0/0", i, rd_sel_wb, rd_data_wb); end
            checks++;
            if (stall_writeback !== 1'b0) begin failures++; $display("FAIL stall got=%b exp=0", stall_writeback); end
`ifdef WB_INSTRET_EN
            checks++;
            if (instret !== 64'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", instret); end
`endif
        end
    endtask

    task automatic test_alu;
        set_pc(32'h100);
        checks++;
        if (current_pc !== 32'h100 || rd_we_wb !== 1'b0) begin failures++; $display("FAIL rsvd_jump pc=%h we=%b exp=00000100/0", current_pc, rd_we_wb); end
        issue(1'b1, 2'b00, 5'd5, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0);
        checks++;
        if (rd_we_wb !== 1'b1) begin failures++; $display("FAIL alu_we got=%b exp=1", rd_we_wb); end
        checks++;
        if (rd_sel_wb !== 5'd5) begin failures++; $display("FAIL alu_sel got=%0d exp=5", rd_sel_wb); end
        checks++;
        if (rd_data_wb !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_data got=%h exp=deadbeef", rd_data_wb); end
        checks++;
        if (current_pc !== 32'h104) begin failures++; $display("FAIL alu_pc got=%h exp=00000104", current_pc); end
        @(negedge clk);
        checks++;
        if (rd_we_wb !== 1'b0) begin failures++; $display("FAIL alu_pulse got=%b exp=0", rd_we_wb); end
        checks++;
        if (rd_data_wb !== 32'hDEADBEEF || current_pc !== 32'h104) begin failures++; $display("FAIL alu_hold data=%h pc=%h exp=deadbeef/00000104", rd_data_wb, current_pc); end
    endtask

    task automatic test_jal;
        set_pc(32'h200);
        issue(1'b1, 2'b10, 5'd1, 1'b1, 32'h400, 32'h0, 32'h0);
        checks++;
        if (rd_data_wb !== 32'h204) begin failures++; $display("FAIL jal_link got=%h exp=00000204", rd_data_wb); end
        checks++;
        if (current_pc !== 32'h400) begin failures++; $display("FAIL jal_pc got=%h exp=00000400", current_pc); end
        checks++;
        if (rd_we_wb !== 1'b1 || rd_sel_wb !== 5'd1) begin failures++; $display("FAIL jal_we we=%b sel=%0d exp=1/1", rd_we_wb, rd_sel_wb); end
    endtask

    task automatic test_x0_load;
        issue(1'b1, 2'b01, 5'd0, 1'b0, 32'h0, 32'h0, 32'h1234);
        checks++;
        if (rd_we_wb !== 1'b0) begin failures++; $display("FAIL x0_we got=%b exp=0", rd_we_wb); end
        checks++;
        if (current_pc !== 32'h404) begin failures++; $display("FAIL x0_pc got=%h exp=00000404", current_pc); end
        issue(1'b1, 2'b01, 5'd7, 1'b0, 32'h0, 32'h0, 32'hFFFFFF80);
        checks++;
        if (rd_data_wb !== 32'hFFFFFF80) begin failures++; $display("FAIL load_data got=%h exp=ffffff80", rd_data_wb); end
        checks++;
        if (rd_we_wb !== 1'b1 || rd_sel_wb !== 5'd7 || current_pc !== 32'h408) begin failures++; $display("FAIL load_ctl we=%b sel=%0d pc=%h exp=1/7/00000408", rd_we_wb, rd_sel_wb, current_pc); end
    endtask

    task automatic test_wrap_reset;
        set_pc(32'hFFFFFFFC);
        issue(1'b1, 2'b10, 5'd3, 1'b0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (current_pc !== 32'h0) begin failures++; $display("FAIL pc_wrap got=%h exp=0", current_pc); end
        checks++;
        if (rd_data_wb !== 32'h0 || rd_we_wb !== 1'b1) begin failures++; $display("FAIL link_wrap data=%h we=%b exp=0/1", rd_data_wb, rd_we_wb); end
        issue(1'b1, 2'b00, 5'd4, 1'b0, 32'h0, 32'h77, 32'h0);
        checks++;
        if (current_pc !== 32'h4 || rd_we_wb !== 1'b1) begin failures++; $display("FAIL pre_rst pc=%h we=%b exp=4/1", current_pc, rd_we_wb); end
        // Reset lands on a phase edge right after a write strobe.
        rst = 1'b1;
        issue(1'b1, 2'b00, 5'd9, 1'b1, 32'h800, 32'h55, 32'h0);
        rst = 1'b0;
        checks++;
        if (current_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", current_pc); end
        checks++;
        if (rd_we_wb !== 1'b0 || rd_sel_wb !== 5'd0 || rd_data_wb !== 32'h0) begin failures++; $display("FAIL rst_rd we=%b sel=%0d data=%h exp=0/0/0", rd_we_wb, rd_sel_wb, rd_data_wb); end
`ifdef WB_INSTRET_EN
        checks++;
        if (instret !== 64'd0) begin failures++; $display("FAIL rst_instret got=%0d exp=0", instret); end
`endif
    endtask

    task automatic test_counter;
        logic       ph  [7] = '{1, 0, 1, 1, 0, 1, 0};
        logic [1:0] sr  [7] = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00};
        logic [4:0] rd  [7] = '{5'd2, 5'd0, 5'd4, 5'd3, 5'd0, 5'd6, 5'd0};
        logic       exp [7] = '{1, 0, 0, 1, 0, 1, 0};
        int pulses = 0;
        for (int i = 0; i < 7; i++) begin
            decoded_op_mw   = {5'b0, sr[i], 1'b1};
            rdsel_mw        = rd[i];
            jump_state_mw   = 1'b0;
            alu_out_mw      = 32'h100 + 32'(i);
            mem_out_mw      = 32'h200 + 32'(i);
            phase_writeback = ph[i];
            @(negedge clk);
            checks++;
            if (rd_we_wb !== exp[i]) begin failures++; $display("FAIL cnt_we cyc=%0d got=%b exp=%b", i, rd_we_wb, exp[i]); end
            if (rd_we_wb === 1'b1) pulses++;
        end
        phase_writeback = 1'b0;
        checks++;
        if (pulses != 3) begin failures++; $display("FAIL cnt_pulses got=%0d exp=3", pulses); end
        checks++;
        if (current_pc !== 32'h10) begin failures++; $display("FAIL cnt_pc got=%h exp=00000010", current_pc); end
`ifdef WB_INSTRET_EN
        checks++;
        if (instret !== 64'd4) begin failures++; $display("FAIL cnt_instret got=%0d exp=4", instret); end
`endif
    endtask

    initial begin
        test_reset;
        test_alu;
        test_jal;
        test_x0_load;
        test_wrap_reset;
        test_counter;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
